huffman_stream_ctrl: RTL
========================

HUFFMAN_STREAM_CTRL -- requirements
Module: huffman_stream_ctrl

Interface
REQ-001 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous active-low reset.
REQ-003 SHALL have port start  input  1  one-cycle pulse; begins a decode job; ignored unless in IDLE.
REQ-004 SHALL have port symbol_count  input  16  number of symbols in the job; sampled on accepted start.
REQ-005 SHALL have port word_data  input  32  encoded bitstream word; MSB is the first bit.
REQ-006 SHALL have port word_valid  input  1  word_data is valid.
REQ-007 SHALL have port word_ready  output  1  controller accepts word_data this cycle.
REQ-008 SHALL have port encodedData  output  6  decoder lookahead window, which is the top 6 buffered bits.
REQ-009 SHALL have port load  output  1  one-cycle strobe; encodedData is valid for the decoder.
REQ-010 SHALL have port ready  input  1  decoder result valid; symbolLength and decodedData are valid.
REQ-011 SHALL have port symbolLength  input  4  bits consumed by the decoded symbol.
REQ-012 SHALL have port decodedData  input  4  decoded symbol value.
REQ-013 SHALL have port sym_data  output  4  emitted symbol value.
REQ-014 SHALL have port sym_valid  output  1  one-cycle strobe; sym_data is valid.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse; the job completed.
REQ-017 SHALL have port err  output  1  sticky flag for an illegal symbolLength; cleared by an accepted start.

Function
REQ-018 SHALL hold a 64-bit MSB-aligned bit buffer with a fill level of 0..64.
REQ-019 SHALL assert word_ready when the state is FILL, PRESENT or WAIT and level<=32.
- An accepted word (word_valid && word_ready) is appended directly below the existing bits.
- level increases by 32.
REQ-020 SHALL use FSM states IDLE, FILL, PRESENT, WAIT and FINISH.
REQ-021 SHALL handle IDLE as follows: on start with symbol_count!=0, clear the buffer, level and err, then go to FILL the next cycle.
- On start with symbol_count==0, go directly to FINISH.
REQ-022 SHALL handle FILL as follows: go to PRESENT once level>=6, including a word accepted in the same cycle.
REQ-023 SHALL handle PRESENT as follows: drive load=1 for exactly one cycle with encodedData equal to buffer[63:58], then go to WAIT.
REQ-024 SHALL handle WAIT as follows: hold encodedData stable and load=0 until ready=1.
REQ-025 SHALL, on ready=1 in WAIT with 1<=symbolLength<=6, do all of the following in that cycle:
- shift the buffer left by symbolLength;
- decrease level by symbolLength;
- pulse sym_valid with sym_data=decodedData;
- decrement the remaining count.
REQ-026 SHALL, after a consume, go to FINISH if remaining is now 0, else to PRESENT if level>=6, else to FILL.
REQ-027 SHALL, when a consume and a word accept occur in the same cycle, place the appended word at bit position (level-symbolLength) of the shifted buffer.
REQ-028 SHALL, on ready=1 in WAIT with symbolLength==0 or >6, set err, consume nothing, emit no symbol and go to FINISH.
REQ-029 SHALL ignore ready in every state except WAIT.
REQ-030 SHALL handle FINISH as follows: pulse done for one cycle, then return to IDLE; leftover buffered bits are discarded.
REQ-031 SHALL ignore start while busy.
REQ-032 SHALL have a latency from ready to the next load of 1 cycle (through PRESENT) when level>=6 after the consume.

Reset
REQ-033 SHALL, while rst=0 at a clock edge, enter IDLE and clear the buffer, level and remaining count.
- load, sym_valid, done, err, busy and word_ready are 0.
- encodedData and sym_data are 0.
REQ-034 SHALL, on reset asserted mid-job, abandon the job without emitting done or sym_valid in the following cycle.

Configuration
REQ-035 SHALL provide a bit counter under the macro HUFF_BITCNT_EN.
- With the macro defined: add output bits_consumed (24 bits), cleared on accepted start and on reset, incremented by symbolLength on each legal consume, saturating at 0xFFFFFF.
- Without the macro: the port and counter are absent, and all other behaviour is identical.

Verification
REQ-036 SHALL cover this scenario:
- Stimulus: start, symbol_count=1, word 0xFC000000; decoder replies ready with symbolLength=6, decodedData=0xA.
- Required: one load with encodedData=6'b111111; sym_valid with sym_data=0xA; done one cycle later; busy low afterward.
REQ-037 SHALL cover this scenario:
- Stimulus: word 0x0BF7F7FF; symbolLength sequence 1,1,1,1,4.
- Required: encodedData sequence 000010, 000101, 001011, 010111, 101111; level after five consumes =24.
REQ-038 SHALL cover this scenario:
- Stimulus: word_valid held low after the first word, and 40 single-bit consumes requested.
- Required: FSM enters FILL at level 5 with load stalled; on the next word, PRESENT occurs with correct bit continuity across the word boundary.
REQ-039 SHALL cover this scenario:
- Stimulus: symbolLength=0 with ready.
- Required: err=1, no sym_valid, done pulse; err cleared by the next start.
REQ-040 SHALL cover this scenario:
- Stimulus: rst=0 asserted while in WAIT.
- Required: all outputs 0 at the next edge; a new start decodes the same stream correctly.

Source files
------------

// File: rtl/huffman_stream_ctrl.sv
// Stream controller feeding a table-driven Huffman decoder: buffers 32-bit words,
// presents 6-bit lookahead windows and consumes decoded lengths. Optional bit counter: HUFF_BITCNT_EN.
module huffman_stream_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] symbol_count,
  input  logic [31:0] word_data,
  input  logic        word_valid,
  output logic        word_ready,
  output logic [5:0]  encodedData,
  output logic        load,
  input  logic        ready,
  input  logic [3:0]  symbolLength,
  input  logic [3:0]  decodedData,
  output logic [3:0]  sym_data,
  output logic        sym_valid,
  output logic        busy,
  output logic        done,
  output logic        err
`ifdef HUFF_BITCNT_EN
  ,
  output logic [23:0] bits_consumed
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL    = 3'd1,
    PRESENT = 3'd2,
    WAIT    = 3'd3,
    FINISH  = 3'd4
  } state_t;

  state_t      state_reg, state_next;
  logic [63:0] buf_reg, buf_next;
  logic [6:0]  level_reg, level_next;
  logic [15:0] remain_reg, remain_next;
  logic        err_reg, err_next;

  logic        accept;
  logic        len_ok;
  logic        consume;
  logic        bad_len;
  logic        active;
  logic [63:0] shifted;
  logic [63:0] appended;
  logic [6:0]  base_level;
  logic [6:0]  filled_level;

  assign active  = (state_reg == FILL) || (state_reg == PRESENT) || (state_reg == WAIT);
  assign accept  = word_valid && word_ready;
  assign len_ok  = (symbolLength != 4'd0) && (symbolLength <= 4'd6);
  assign consume = (state_reg == WAIT) && ready && len_ok;
  assign bad_len = (state_reg == WAIT) && ready && !len_ok;

  // Consume first, then append the new word directly below the surviving bits.
  always_comb begin
    shifted      = consume ? (buf_reg << symbolLength) : buf_reg;
    base_level   = consume ? (level_reg - {3'b000, symbolLength}) : level_reg;
    appended     = accept ? (shifted | ({word_data, 32'h0000_0000} >> base_level)) : shifted;
    filled_level = accept ? (base_level + 7'd32) : base_level;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (symbol_count == 16'd0) ? FINISH : FILL;
        end
      end
      FILL: begin
        if (filled_level >= 7'd6) begin
          state_next = PRESENT;
        end
      end
      PRESENT: state_next = WAIT;
      WAIT: begin
        if (ready) begin
          if (!len_ok || (remain_reg == 16'd1)) begin
            state_next = FINISH;
          end else if (filled_level >= 7'd6) begin
            state_next = PRESENT;
          end else begin
            state_next = FILL;
          end
        end
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    word_ready  = active && (level_reg <= 7'd32);
    load        = (state_reg == PRESENT);
    encodedData = buf_reg[63:58];
    sym_valid   = consume;
    sym_data    = consume ? decodedData : 4'd0;
    busy        = (state_reg != IDLE);
    done        = (state_reg == FINISH);
    err         = err_reg;
  end

  // Buffer, fill level, remaining count and error flag
  always_comb begin
    buf_next    = buf_reg;
    level_next  = level_reg;
    remain_next = remain_reg;
    err_next    = err_reg;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          buf_next    = 64'd0;
          level_next  = 7'd0;
          remain_next = symbol_count;
          err_next    = 1'b0;
        end
      end
      FILL, PRESENT, WAIT: begin
        buf_next   = appended;
        level_next = filled_level;
        if (consume) begin
          remain_next = remain_reg - 16'd1;
        end
        if (bad_len) begin
          err_next = 1'b1;
        end
      end
      FINISH: begin
        // Leftover bits belong to the finished job and are dropped here.
        buf_next    = 64'd0;
        level_next  = 7'd0;
        remain_next = 16'd0;
      end
      default: begin
        buf_next    = 64'd0;
        level_next  = 7'd0;
        remain_next = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_reg    <= 64'd0;
      level_reg  <= 7'd0;
      remain_reg <= 16'd0;
      err_reg    <= 1'b0;
    end else begin
      buf_reg    <= buf_next;
      level_reg  <= level_next;
      remain_reg <= remain_next;
      err_reg    <= err_next;
    end
  end

`ifdef HUFF_BITCNT_EN
  logic [23:0] bitcnt_reg, bitcnt_next;
  logic [24:0] bitcnt_sum;

  always_comb begin
    bitcnt_sum  = {1'b0, bitcnt_reg} + {21'd0, symbolLength};
    bitcnt_next = bitcnt_reg;
    if ((state_reg == IDLE) && start) begin
      bitcnt_next = 24'd0;
    end else if (consume) begin
      bitcnt_next = bitcnt_sum[24] ? 24'hFF_FFFF : bitcnt_sum[23:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bitcnt_reg <= 24'd0;
    end else begin
      bitcnt_reg <= bitcnt_next;
    end
  end

  assign bits_consumed = bitcnt_reg;
`endif

endmodule
